cnn_mac_pipe: RTL and testbench
===============================

// Module: cnn_mac_pipe
// PURPOSE
//  Parametrised signed multiply / multiply-accumulate unit for CNN conv and dense layers.
//  Generalises the single-stage 18x18 DSP multiplier: configurable operand widths, pipeline depth,
//  valid tagging and an accumulate mode that sums a burst of products into one result.
//  Sits between the layer datapath (weight x activation) and the output/bias stage.
// PARAMETERS
//  A_WIDTH     18  signed width of din0
//  B_WIDTH     18  signed width of din1
//  NUM_STAGE   2   multiplier pipeline registers, legal 1..4
//  MODE        1   0 = plain multiply (dout = product), 1 = accumulate over first..last burst
//  ACC_WIDTH   48  accumulator / dout width, must be >= A_WIDTH+B_WIDTH
// PORTS
//  clk        in   1          rising-edge clock
//  reset      in   1          asynchronous, active-high reset
//  ce         in   1          clock enable; low freezes every register in the block
//  in_valid   in   1          din0/din1/in_first/in_last qualify this beat
//  in_first   in   1          MODE 1: beat starts a new accumulation (ignored in MODE 0)
//  in_last    in   1          MODE 1: beat ends the accumulation (ignored in MODE 0)
//  din0       in   A_WIDTH    signed operand A
//  din1       in   B_WIDTH    signed operand B
//  dout       out  ACC_WIDTH  signed product (MODE 0) or accumulated sum (MODE 1)
//  dout_valid out  1          one-cycle strobe, dout valid
//  ovf        out  1          sticky: accumulator overflowed since reset
// BEHAVIOUR
//  - Reset (async assert, sync release in clk domain): all pipeline data, valid/tag bits, accumulator,
//    dout, dout_valid, ovf -> 0.
//  - Product P = signed(din0)*signed(din1), full A_WIDTH+B_WIDTH bits, sign-extended to ACC_WIDTH.
//  - Valid, first, last travel alongside data through NUM_STAGE registers; all advance only when ce=1.
//  - MODE 0: dout_valid rises NUM_STAGE ce-cycles after accepted beat; dout = P. No bubbles required,
//    one result per ce-cycle throughput.
//  - MODE 1: one extra accumulate stage, latency NUM_STAGE+1 ce-cycles.
//    ACC state: IDLE (no burst open) / RUN (burst open).
//    first=1: acc <= P, state RUN (a first arriving in RUN discards the open partial sum).
//    first=0 in RUN: acc <= acc + P.  first=0 in IDLE: beat dropped, acc unchanged.
//    last=1 (in a beat that is accepted into the acc): dout <= updated sum, dout_valid=1, state IDLE.
//    first=last=1: dout = P alone.  Invalid beats never touch acc.
//  - Overflow: sum exceeding signed ACC_WIDTH range sets ovf (sticky until reset).
//  - ce=0 with pending results: dout/dout_valid hold their values; dout_valid held high is not
//    re-counted as a new result by consumers, who sample on ce.
//  - reset mid-burst: partial sum lost, state IDLE, in-flight beats discarded.
// CONFIGURATION
//  CNN_MAC_SAT_EN defined: accumulate saturates to +2^(ACC_WIDTH-1)-1 / -2^(ACC_WIDTH-1) on
//    overflow and ovf is set.  Undefined: two's-complement wrap, ovf still set on overflow.
//  MODE 0 never overflows (ACC_WIDTH >= product width), so the macro has no effect there.
// STRUCTURE
//  Package cnn_mac_pkg: MODE_MUL/MODE_MAC constants, NUM_STAGE min/max constants,
//    acc_state_t enum {ACC_IDLE, ACC_RUN}, saturate() function used by the accumulate stage.
//  Sub-module cnn_mac_mul_pipe: signed A x B multiplier with NUM_STAGE registers and ce,
//    carrying the valid/first/last sideband; DSP-inferable (no reset on data regs except as required).
//  Top cnn_mac_pipe: instantiates cnn_mac_mul_pipe, adds accumulate stage, state, ovf, output regs.
// TESTING
//  1 MODE 0, NUM_STAGE=2: din0=-3,din1=7 valid one beat -> dout=-21, dout_valid high exactly 2 cycles later.
//  2 MODE 1: products 2*3,4*5,-1*6 with first on beat 1, last on beat 3 -> single strobe, dout=20.
//  3 ce toggled low for 3 cycles mid-burst of test 2 -> same dout=20, latency stretched by 3 cycles.
//  4 first=last=1, din0=-131072,din1=-131072 -> dout=2^34, ovf=0; first arriving mid-burst restarts sum.
//  5 ACC_WIDTH=36, burst of 4 x (131071*131071): SAT_EN -> dout=2^35-1, ovf=1; else wrapped value, ovf=1.
//  6 reset asserted asynchronously mid-burst -> dout, dout_valid, ovf = 0 immediately; next burst correct.

Source files
------------

// File: rtl/cnn_mac_pkg.sv
// Shared constants, types and helpers for the CNN multiply / multiply-accumulate unit.
// The optional CNN_MAC_SAT_EN build uses saturate() in the accumulate stage.
package cnn_mac_pkg;

  localparam int unsigned MODE_MUL      = 0;
  localparam int unsigned MODE_MAC      = 1;
  localparam int unsigned NUM_STAGE_MIN = 1;
  localparam int unsigned NUM_STAGE_MAX = 4;
  localparam int unsigned ACC_MAX_W     = 128;

  typedef enum logic {
    ACC_IDLE,
    ACC_RUN
  } acc_state_t;

  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } mac_tag_t;

  // Clamp to the signed limit of a width-bit accumulator when ovf is set; neg picks the rail.
  function automatic logic [ACC_MAX_W-1:0] saturate(input logic [ACC_MAX_W-1:0] sum,
                                                    input logic                 ovf,
                                                    input logic                 neg,
                                                    input int unsigned          width);
    logic [ACC_MAX_W-1:0] lim;
    for (int unsigned i = 0; i < ACC_MAX_W; i++) begin
      lim[i] = (i < width - 1) ? ~neg : neg;
    end
    return ovf ? lim : sum;
  endfunction

endpackage

// File: rtl/cnn_mac_mul_pipe.sv
// Signed A x B multiplier followed by NUM_STAGE registers, carrying the valid/first/last tag.
module cnn_mac_mul_pipe
  import cnn_mac_pkg::*;
#(
  parameter int unsigned A_WIDTH   = 18,
  parameter int unsigned B_WIDTH   = 18,
  parameter int unsigned NUM_STAGE = 2
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               ce,
  input  mac_tag_t                           tag_i,
  input  logic signed [A_WIDTH-1:0]          a_i,
  input  logic signed [B_WIDTH-1:0]          b_i,
  output mac_tag_t                           tag_o,
  output logic signed [A_WIDTH+B_WIDTH-1:0]  prod_o
);

  localparam int unsigned P_WIDTH = A_WIDTH + B_WIDTH;

  logic signed [P_WIDTH-1:0] prod_c;
  logic signed [P_WIDTH-1:0] prod_q [NUM_STAGE];
  mac_tag_t                  tag_q  [NUM_STAGE];

  assign prod_c = P_WIDTH'(a_i) * P_WIDTH'(b_i);

  // Product and sideband shift together; ce freezes the whole chain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_STAGE; i++) begin
        prod_q[i] <= '0;
        tag_q[i]  <= '0;
      end
    end else if (ce) begin
      prod_q[0] <= prod_c;
      tag_q[0]  <= tag_i;
      for (int i = 1; i < NUM_STAGE; i++) begin
        prod_q[i] <= prod_q[i-1];
        tag_q[i]  <= tag_q[i-1];
      end
    end
  end

  assign prod_o = prod_q[NUM_STAGE-1];
  assign tag_o  = tag_q[NUM_STAGE-1];

endmodule

// File: rtl/cnn_mac_pipe.sv
// Signed multiply (MODE 0) or burst multiply-accumulate (MODE 1) unit for CNN layers.
// Define CNN_MAC_SAT_EN to saturate the accumulator on overflow instead of wrapping.
module cnn_mac_pipe
  import cnn_mac_pkg::*;
#(
  parameter int unsigned A_WIDTH   = 18,
  parameter int unsigned B_WIDTH   = 18,
  parameter int unsigned NUM_STAGE = 2,
  parameter int unsigned MODE      = 1,
  parameter int unsigned ACC_WIDTH = 48
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        ce,
  input  logic                        in_valid,
  input  logic                        in_first,
  input  logic                        in_last,
  input  logic signed [A_WIDTH-1:0]   din0,
  input  logic signed [B_WIDTH-1:0]   din1,
  output logic signed [ACC_WIDTH-1:0] dout,
  output logic                        dout_valid,
  output logic                        ovf
);

  localparam int unsigned P_WIDTH = A_WIDTH + B_WIDTH;
  localparam int unsigned SUM_W   = ACC_WIDTH + 1;

  mac_tag_t                    tag_in_c;
  mac_tag_t                    tag_pipe;
  logic signed [P_WIDTH-1:0]   prod_pipe;
  logic signed [ACC_WIDTH-1:0] prod_ext_c;

  assign tag_in_c   = '{valid: in_valid, first: in_first, last: in_last};
  assign prod_ext_c = ACC_WIDTH'(prod_pipe);

  cnn_mac_mul_pipe #(
    .A_WIDTH  (A_WIDTH),
    .B_WIDTH  (B_WIDTH),
    .NUM_STAGE(NUM_STAGE)
  ) u_mul_pipe (
    .clk   (clk),
    .reset (reset),
    .ce    (ce),
    .tag_i (tag_in_c),
    .a_i   (din0),
    .b_i   (din1),
    .tag_o (tag_pipe),
    .prod_o(prod_pipe)
  );

  generate
    if (MODE == MODE_MUL) begin : g_mul
      logic unused_tag_c;
      assign unused_tag_c = tag_pipe.first ^ tag_pipe.last;

      // Last multiplier register is the output register.
      assign dout       = prod_ext_c;
      assign dout_valid = tag_pipe.valid;
      assign ovf        = 1'b0;
    end else begin : g_mac
      acc_state_t                  state_q;
      logic signed [ACC_WIDTH-1:0] acc_q;
      logic signed [ACC_WIDTH-1:0] dout_q;
      logic                        dout_valid_q;
      logic                        ovf_q;
      logic signed [SUM_W-1:0]     sum_wide_c;
      logic                        sum_ovf_c;
      logic signed [ACC_WIDTH-1:0] sum_d;

      // One guard bit exposes overflow: the two top bits disagree.
      assign sum_wide_c = SUM_W'(acc_q) + SUM_W'(prod_ext_c);
      assign sum_ovf_c  = sum_wide_c[ACC_WIDTH] ^ sum_wide_c[ACC_WIDTH-1];

`ifdef CNN_MAC_SAT_EN
      assign sum_d = ACC_WIDTH'(saturate(ACC_MAX_W'(sum_wide_c), sum_ovf_c,
                                         sum_wide_c[ACC_WIDTH], ACC_WIDTH));
`else
      assign sum_d = sum_wide_c[ACC_WIDTH-1:0];
`endif

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          state_q      <= ACC_IDLE;
          acc_q        <= '0;
          dout_q       <= '0;
          dout_valid_q <= 1'b0;
          ovf_q        <= 1'b0;
        end else if (ce) begin
          dout_valid_q <= 1'b0;
          if (tag_pipe.valid) begin
            if (tag_pipe.first) begin
              // A first always restarts, discarding any open partial sum.
              acc_q   <= prod_ext_c;
              state_q <= tag_pipe.last ? ACC_IDLE : ACC_RUN;
              if (tag_pipe.last) begin
                dout_q       <= prod_ext_c;
                dout_valid_q <= 1'b1;
              end
            end else if (state_q == ACC_RUN) begin
              acc_q <= sum_d;
              if (sum_ovf_c) begin
                ovf_q <= 1'b1;
              end
              if (tag_pipe.last) begin
                dout_q       <= sum_d;
                dout_valid_q <= 1'b1;
                state_q      <= ACC_IDLE;
              end
            end
          end
        end
      end

      assign dout       = dout_q;
      assign dout_valid = dout_valid_q;
      assign ovf        = ovf_q;
    end
  endgenerate

endmodule

// File: tb/tb_cnn_mac_pipe.sv
// Directed bench for cnn_mac_pipe: a MODE 0 multiplier, a 48-bit MAC and a 36-bit MAC share stimulus.
module tb_cnn_mac_pipe;

  logic clk = 1'b0;
  logic reset, ce, in_valid, in_first, in_last;
  logic signed [17:0] din0, din1;

  logic signed [47:0] dout_mul, dout_mac;
  logic signed [35:0] dout_36;
  logic dv_mul, dv_mac, dv_36, ovf_mul, ovf_mac, ovf_36;

  always #5 clk = ~clk;

  cnn_mac_pipe #(.A_WIDTH(18), .B_WIDTH(18), .NUM_STAGE(2), .MODE(0), .ACC_WIDTH(48)) u_mul (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_first(in_first), .in_last(in_last),
    .din0(din0), .din1(din1), .dout(dout_mul), .dout_valid(dv_mul), .ovf(ovf_mul));

  cnn_mac_pipe #(.A_WIDTH(18), .B_WIDTH(18), .NUM_STAGE(2), .MODE(1), .ACC_WIDTH(48)) u_mac (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_first(in_first), .in_last(in_last),
    .din0(din0), .din1(din1), .dout(dout_mac), .dout_valid(dv_mac), .ovf(ovf_mac));

  cnn_mac_pipe #(.A_WIDTH(18), .B_WIDTH(18), .NUM_STAGE(2), .MODE(1), .ACC_WIDTH(36)) u_mac36 (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_first(in_first), .in_last(in_last),
    .din0(din0), .din1(din1), .dout(dout_36), .dout_valid(dv_36), .ovf(ovf_36));

  int n_tests = 0;
  int n_fail  = 0;
  int iter    = 0;

  // Output samples from the last negedge, and results as a ce-qualified consumer would take them.
  logic               pv_mul = 1'b0, pv_mac = 1'b0, pv_36 = 1'b0;
  logic signed [47:0] pd_mul, pd_mac;
  logic signed [35:0] pd_36;
  int                 cnt_mul = 0, cnt_mac = 0, cnt_36 = 0;
  int                 it_mul = 0, it_mac = 0, it_36 = 0;
  logic signed [47:0] got_mul = '0, got_mac = '0;
  logic signed [35:0] got_36 = '0;

  task automatic check(input string tag, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  function automatic int cnt_of(input int which);
    case (which)
      0:       return cnt_mul;
      1:       return cnt_mac;
      default: return cnt_36;
    endcase
  endfunction

  // Drive one cycle's inputs, consume strobes seen by the coming edge, then sample at negedge.
  task automatic beat(input logic c, input logic v, input logic f, input logic l,
                      input int a, input int b);
    ce = c; in_valid = v; in_first = f; in_last = l;
    din0 = 18'(a); din1 = 18'(b);
    iter++;
    if (c) begin
      if (pv_mul) begin cnt_mul++; it_mul = iter; got_mul = pd_mul; end
      if (pv_mac) begin cnt_mac++; it_mac = iter; got_mac = pd_mac; end
      if (pv_36)  begin cnt_36++;  it_36  = iter; got_36  = pd_36;  end
    end
    @(negedge clk);
    pv_mul = dv_mul; pd_mul = dout_mul;
    pv_mac = dv_mac; pd_mac = dout_mac;
    pv_36  = dv_36;  pd_36  = dout_36;
  endtask

  task automatic idle(input int n);
    repeat (n) beat(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic wait_strobe(input string tag, input int which, input int c0);
    for (int i = 0; i < 20 && cnt_of(which) == c0; i++) idle(1);
    check({tag, "_seen"}, 64'(cnt_of(which) != c0), 64'sd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int b;
    int c0;
    reset = 1'b1; ce = 1'b0; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    din0 = '0; din1 = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_dout_mul", dout_mul, 0);
    check("rst_dv_mul",   dv_mul,   0);
    check("rst_dout_mac", dout_mac, 0);
    check("rst_dv_mac",   dv_mac,   0);
    check("rst_ovf_mac",  ovf_mac,  0);
    reset = 1'b0;
    idle(2);

    // Plain multiply: latency 2, single-cycle strobe, back-to-back throughput.
    c0 = cnt_mul;
    beat(1, 1, 0, 0, -3, 7); b = iter;
    wait_strobe("t1", 0, c0);
    check("t1_dout", got_mul, -21);
    check("t1_lat",  it_mul - b, 2);
    check("t1_dv_low", pv_mul, 0);
    beat(1, 1, 0, 0, 5, 6);
    beat(1, 1, 0, 0, -7, 8);
    idle(1);
    check("t1_b2b_0", got_mul, 30);
    idle(1);
    check("t1_b2b_1", got_mul, -56);
    idle(3);

    // Accumulate 6 + 20 - 6 = 20, latency 3, one strobe.
    c0 = cnt_mac;
    beat(1, 1, 1, 0, 2, 3);
    beat(1, 1, 0, 0, 4, 5);
    beat(1, 1, 0, 1, -1, 6); b = iter;
    wait_strobe("t2", 1, c0);
    check("t2_dout", got_mac, 20);
    check("t2_lat",  it_mac - b, 3);
    idle(4);
    check("t2_count", cnt_mac, c0 + 1);

    // ce low for 3 cycles while the last beat is in flight.
    c0 = cnt_mac;
    beat(1, 1, 1, 0, 2, 3);
    beat(1, 1, 0, 0, 4, 5);
    beat(1, 1, 0, 1, -1, 6); b = iter;
    repeat (3) beat(0, 0, 0, 0, 0, 0);
    wait_strobe("t3", 1, c0);
    check("t3_dout", got_mac, 20);
    check("t3_lat",  it_mac - b, 6);
    idle(4);
    check("t3_count", cnt_mac, c0 + 1);

    // ce low while dout_valid is high: held, taken once.
    c0 = cnt_mac;
    beat(1, 1, 1, 0, 2, 3);
    beat(1, 1, 0, 0, 4, 5);
    beat(1, 1, 0, 1, -1, 6); b = iter;
    idle(2);
    check("t3b_dv_high", pv_mac, 1);
    repeat (2) beat(0, 0, 0, 0, 0, 0);
    check("t3b_dv_held", pv_mac, 1);
    wait_strobe("t3b", 1, c0);
    check("t3b_dout", got_mac, 20);
    check("t3b_lat",  it_mac - b, 5);
    idle(4);
    check("t3b_count", cnt_mac, c0 + 1);

    // first=last on the most negative operands, then a first that restarts an open burst.
    c0 = cnt_mac;
    beat(1, 1, 1, 1, -131072, -131072);
    wait_strobe("t4a", 1, c0);
    check("t4a_dout", got_mac, 64'sd17179869184);
    check("t4a_ovf",  ovf_mac, 0);
    idle(3);
    c0 = cnt_mac;
    beat(1, 1, 1, 0, 2, 3);
    beat(1, 1, 0, 0, 4, 5);
    beat(1, 1, 1, 0, 1, 7);
    beat(1, 1, 0, 1, 2, 2);
    wait_strobe("t4b", 1, c0);
    check("t4b_dout", got_mac, 11);
    idle(4);
    check("t4b_count", cnt_mac, c0 + 1);

    // Four max-positive products overflow a 36-bit accumulator but not a 48-bit one.
    c0 = cnt_36;
    beat(1, 1, 1, 0, 131071, 131071);
    beat(1, 1, 0, 0, 131071, 131071);
    beat(1, 1, 0, 0, 131071, 131071);
    beat(1, 1, 0, 1, 131071, 131071);
    wait_strobe("t5", 2, c0);
`ifdef CNN_MAC_SAT_EN
    check("t5_dout36", got_36, 64'sd34359738367);
`else
    check("t5_dout36", got_36, -64'sd1048572);
`endif
    check("t5_ovf36",   ovf_36,  1);
    check("t5_dout48",  got_mac, 64'sd68718428164);
    check("t5_ovf48",   ovf_mac, 0);
    idle(3);

    // Asynchronous reset mid-burst clears outputs without waiting for an edge.
    beat(1, 1, 1, 0, 3, 3);
    beat(1, 1, 0, 0, 3, 3);
    #2 reset = 1'b1;
    #1;
    check("t6_dout36", dout_36, 0);
    check("t6_dv36",   dv_36,   0);
    check("t6_ovf36",  ovf_36,  0);
    check("t6_dout48", dout_mac, 0);
    @(negedge clk);
    reset = 1'b0;
    pv_mul = 1'b0; pv_mac = 1'b0; pv_36 = 1'b0;
    idle(1);
    c0 = cnt_36;
    beat(1, 1, 0, 1, 9, 9);
    beat(1, 1, 1, 0, 2, 3);
    beat(1, 1, 0, 1, 4, 5);
    wait_strobe("t6", 2, c0);
    check("t6_next_dout", got_36, 26);
    check("t6_next_ovf",  ovf_36, 0);
    idle(4);
    check("t6_count", cnt_36, c0 + 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
